ddr_wr_rr_scheduler: RTL and testbench
======================================

DDR_WR_RR_SCHEDULER -- requirements
Module: ddr_wr_rr_scheduler

Interface
REQ-001 Parameter MEM_DQ_WIDTH, default 16, DDR data width per beat.
REQ-002 Parameter CTRL_ADDR_WIDTH, default 28, DDR controller address width.
REQ-003 Parameter BURST_LENGTH, default 8, beats packed per data word; DW = MEM_DQ_WIDTH*BURST_LENGTH.
REQ-004 Parameter DEVICE_NUM, default 4, requester count, supported range 2..8; IW = clog2(DEVICE_NUM).
REQ-005 Parameter TIMEOUT, default 256, maximum cycles in ST_REQ without core busy.
REQ-006 i_axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 i_rstn  in  1  asynchronous, active-low reset.
REQ-008 i_init_ack  in  1  DDR controller initialisation done.
REQ-009 i_req  in  DEVICE_NUM  per-requester write request, level.
REQ-010 i_ready  in  DEVICE_NUM  per-requester data ready, level.
REQ-011 i_addr  in  DEVICE_NUM*CTRL_ADDR_WIDTH  packed start addresses; slice k = requester k.
REQ-012 i_wdata  in  DEVICE_NUM*DW  packed write data; slice k = requester k.
REQ-013 o_core_rq  out  1  write request to the DDR write core.
REQ-014 o_core_addr  out  CTRL_ADDR_WIDTH  start address to the core.
REQ-015 o_core_wdata  out  DW  write data to the core.
REQ-016 i_core_busy  in  1  core busy, high for the whole burst.
REQ-017 o_sel  out  DEVICE_NUM  one-hot grant; all-zero when no grant.
REQ-018 o_grant_idx  out  IW  binary index of the current grant.
REQ-019 o_done  out  1  one-cycle pulse when a granted transfer completes.
REQ-020 o_timeout  out  1  one-cycle pulse when a grant is abandoned by timeout.

Function
REQ-021 State register SHALL encode ST_IDLE, ST_ARB, ST_REQ and ST_BUSY.
REQ-022 ST_IDLE -> ST_ARB on the first clock with i_init_ack=1; i_init_ack is ignored in every other state.
REQ-023 eligible[k] = i_req[k] AND i_ready[k], evaluated combinationally in ST_ARB only.
REQ-024 ST_ARB with eligible=0 stays ST_ARB; otherwise -> ST_REQ, granting the first eligible index searched upward from last_ptr+1 modulo DEVICE_NUM.
REQ-025 On the grant edge, o_sel, o_grant_idx and o_core_addr SHALL register the winner's one-hot, index and i_addr slice; o_core_addr holds until the next grant.
REQ-026 o_core_rq = 1 exactly while state is ST_REQ (decoded from the state flop, glitch-free).
REQ-027 ST_REQ -> ST_BUSY on the first clock with i_core_busy=1; the timeout counter clears on entry to ST_REQ.
REQ-028 ST_REQ with the counter reaching TIMEOUT-1 and i_core_busy=0 -> ST_ARB, with o_timeout pulsed for one cycle on that edge.
REQ-029 ST_BUSY -> ST_ARB on the first clock with i_core_busy=0, with o_done pulsed for one cycle on that edge.
REQ-030 On every exit from ST_REQ-by-timeout or ST_BUSY: last_ptr <= o_grant_idx, and o_sel <= 0; o_grant_idx retains its value.
REQ-031 o_core_wdata = i_wdata slice selected by o_grant_idx whenever o_sel != 0, else all zeros (combinational mux).
REQ-032 Requester deassertion of i_req after grant SHALL NOT abort the transfer; the grant ends only per REQ-028/REQ-029.
REQ-033 Minimum turnaround: one ST_ARB cycle between consecutive grants.
REQ-034 A single continuously eligible requester SHALL be re-granted on every arbitration, with no idle gaps beyond REQ-033.

Reset
REQ-035 On i_rstn=0, immediately: state=ST_IDLE, last_ptr=DEVICE_NUM-1 (device 0 wins first), counter=0.
REQ-036 Reset outputs: o_core_rq=0, o_core_addr=0, o_sel=0, o_grant_idx=0, o_done=0, o_timeout=0, o_core_wdata=0.
REQ-037 Reset asserted mid-transfer SHALL abandon the grant with no o_done or o_timeout pulse; after release the block waits for i_init_ack again.

Verification
REQ-038 i_init_ack=0, i_req=i_ready=4'b1111 for 20 cycles -> o_core_rq=0 and o_sel=0 throughout.
REQ-039 init done, all four eligible, core busy for 10 cycles per request -> grant order 0,1,2,3,0, with o_done pulsed once per grant.
REQ-040 Requester 2 only eligible, with i_addr slice 2 = 28'h0001000 -> o_sel=4'b0100, o_core_addr=28'h0001000, o_core_rq high until busy, o_core_wdata = slice 2.
REQ-041 Grant to device 1, i_core_busy held 0 -> o_timeout pulses after exactly 256 ST_REQ cycles, then the next grant goes to device 2 if eligible.
REQ-042 i_rstn pulsed low while in ST_BUSY -> all outputs zero asynchronously, no o_done; after release plus i_init_ack, device 0 is granted first.
REQ-043 Requesters 0 and 3 eligible, last grant 3 -> device 0 granted next, then 3, alternating.

Source files
------------

// File: rtl/ddr_wr_rr_scheduler.sv
// Round-robin write scheduler: arbitrates DEVICE_NUM requesters onto a single DDR write core,
// with a timeout that gives up on a grant if the core never goes busy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for DDR controller init done
// ST_ARB  | picking the next eligible requester after last_ptr
// ST_REQ  | o_core_rq asserted, waiting for the core to go busy
// ST_BUSY | core is bursting; grant ends when busy drops
module ddr_wr_rr_scheduler #(
   parameter int MEM_DQ_WIDTH    = 16,
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int BURST_LENGTH    = 8,
   parameter int DEVICE_NUM      = 4,
   parameter int TIMEOUT         = 256,
   localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH,
   localparam int IW = $clog2(DEVICE_NUM)
) (
   input  logic                                  i_axi_aclk,
   input  logic                                  i_rstn,
   input  logic                                  i_init_ack,
   input  logic [DEVICE_NUM-1:0]                 i_req,
   input  logic [DEVICE_NUM-1:0]                 i_ready,
   input  logic [DEVICE_NUM*CTRL_ADDR_WIDTH-1:0] i_addr,
   input  logic [DEVICE_NUM*DW-1:0]              i_wdata,
   output logic                                  o_core_rq,
   output logic [CTRL_ADDR_WIDTH-1:0]            o_core_addr,
   output logic [DW-1:0]                         o_core_wdata,
   input  logic                                  i_core_busy,
   output logic [DEVICE_NUM-1:0]                 o_sel,
   output logic [IW-1:0]                         o_grant_idx,
   output logic                                  o_done,
   output logic                                  o_timeout
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_REQ  = 2'd2,
      ST_BUSY = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              last_ptr_q, last_ptr_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [DEVICE_NUM-1:0]      sel_q, sel_d;
   logic [IW-1:0]              grant_idx_q, grant_idx_d;
   logic [CTRL_ADDR_WIDTH-1:0] core_addr_q, core_addr_d;
   logic                       done_q, done_d;
   logic                       timeout_q, timeout_d;

   logic [DEVICE_NUM-1:0]      eligible;
   logic [IW-1:0]              win_idx;
   logic                       win_found;

   logic [CTRL_ADDR_WIDTH-1:0] addr_arr  [DEVICE_NUM];
   logic [DW-1:0]              wdata_arr [DEVICE_NUM];

   for (genvar k = 0; k < DEVICE_NUM; k++) begin : g_slice
      assign addr_arr[k]  = i_addr[k*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
      assign wdata_arr[k] = i_wdata[k*DW +: DW];
   end

   assign eligible = i_req & i_ready;

   // Upward search starting one past the last winner, wrapping at DEVICE_NUM.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = 1; i <= DEVICE_NUM; i++) begin
         if (!win_found && eligible[(int'(last_ptr_q) + i) % DEVICE_NUM]) begin
            win_found = 1'b1;
            win_idx   = IW'((int'(last_ptr_q) + i) % DEVICE_NUM);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_ptr_d  = last_ptr_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      grant_idx_d = grant_idx_q;
      core_addr_d = core_addr_q;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_init_ack) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (win_found) begin
               state_d     = ST_REQ;
               sel_d       = {{(DEVICE_NUM-1){1'b0}}, 1'b1} << win_idx;
               grant_idx_d = win_idx;
               core_addr_d = addr_arr[win_idx];
               cnt_d       = '0;
            end
         end
         ST_REQ: begin
            if (i_core_busy) begin
               state_d = ST_BUSY;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d    = ST_ARB;
               timeout_d  = 1'b1;
               last_ptr_d = grant_idx_q;
               sel_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_BUSY: begin
            if (!i_core_busy) begin
               state_d    = ST_ARB;
               done_d     = 1'b1;
               last_ptr_d = grant_idx_q;
               sel_d      = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         last_ptr_q  <= IW'(DEVICE_NUM - 1);
         cnt_q       <= '0;
         sel_q       <= '0;
         grant_idx_q <= '0;
         core_addr_q <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_ptr_q  <= last_ptr_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         grant_idx_q <= grant_idx_d;
         core_addr_q <= core_addr_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_core_rq    = (state_q == ST_REQ);
   assign o_core_addr  = core_addr_q;
   assign o_sel        = sel_q;
   assign o_grant_idx  = grant_idx_q;
   assign o_done       = done_q;
   assign o_timeout    = timeout_q;
   assign o_core_wdata = (sel_q != '0) ? wdata_arr[grant_idx_q] : '0;

endmodule

// File: tb/tb_ddr_wr_rr_scheduler.sv
// Bench for ddr_wr_rr_scheduler: directed scenarios plus randomized transfers checked
// against a transaction-level round-robin model.
module tb_ddr_wr_rr_scheduler;

   localparam int CAW = 28;
   localparam int DW  = 128;
   localparam int N   = 4;

   logic           clk;
   logic           rstn;
   logic           init_ack;
   logic [N-1:0]   req, rdy;
   logic [N*CAW-1:0] addr;
   logic [N*DW-1:0]  wdata;
   logic           core_rq;
   logic [CAW-1:0] core_addr;
   logic [DW-1:0]  core_wdata;
   logic           core_busy;
   logic [N-1:0]   sel;
   logic [1:0]     grant_idx;
   logic           done;
   logic           tmo;

   int checks   = 0;
   int failures = 0;
   int m_last   = N - 1;

   ddr_wr_rr_scheduler dut (
      .i_axi_aclk  (clk),
      .i_rstn      (rstn),
      .i_init_ack  (init_ack),
      .i_req       (req),
      .i_ready     (rdy),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .o_core_rq   (core_rq),
      .o_core_addr (core_addr),
      .o_core_wdata(core_wdata),
      .i_core_busy (core_busy),
      .o_sel       (sel),
      .o_grant_idx (grant_idx),
      .o_done      (done),
      .o_timeout   (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [N-1:0] elig);
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (last + i) % N;
         if (elig[c]) return c;
      end
      return -1;
   endfunction

   task automatic randomize_data();
      for (int k = 0; k < N; k++) begin
         addr[k*CAW +: CAW] = CAW'($urandom);
         wdata[k*DW +: DW]  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rq"},    core_rq,    1'b0);
      check({tag, "_addr"},  core_addr,  '0);
      check({tag, "_sel"},   sel,        '0);
      check({tag, "_idx"},   grant_idx,  '0);
      check({tag, "_done"},  done,       1'b0);
      check({tag, "_tmo"},   tmo,        1'b0);
      check({tag, "_wdata"}, core_wdata, '0);
   endtask

   // One granted transfer; returns at the negedge where o_done or o_timeout is visible,
   // so the caller can change requests before the following arbitration edge.
   task automatic xfer(input logic [N-1:0] r, input logic [N-1:0] y, input int dly,
                       input int blen, input bit to, input bit drop, input bit b2b,
                       input int want);
      int exp_idx;
      int waited;
      bit seen;
      int n;
      logic [N-1:0] exp_sel;
      req = r;
      rdy = y;
      exp_idx = rr_pick(m_last, r & y);
      exp_sel = N'(1) << exp_idx;
      waited = 0;
      seen = 1'b0;
      while (!seen && waited < 20) begin
         @(negedge clk);
         waited++;
         if (core_rq) seen = 1'b1;
      end
      check("grant_seen", seen, 1'b1);
      if (b2b) check("turnaround", waited, 1);
      if (want >= 0) check("directed_idx", grant_idx, want);
      check("sel",       sel,        exp_sel);
      check("grant_idx", grant_idx,  exp_idx);
      check("core_addr", core_addr,  addr[exp_idx*CAW +: CAW]);
      check("wdata",     core_wdata, wdata[exp_idx*DW +: DW]);
      check("pulse_width", {done, tmo}, 2'b00);
      if (drop) req = '0;
      if (to) begin
         n = 1;
         while (n < 300) begin
            @(negedge clk);
            if (!core_rq) break;
            n++;
         end
         check("timeout_len", n, 256);
         check("timeout_pulse", tmo, 1'b1);
         check("timeout_nodone", done, 1'b0);
         check("timeout_sel", sel, '0);
         check("timeout_idx_hold", grant_idx, exp_idx);
         check("timeout_wdata", core_wdata, '0);
      end else begin
         repeat (dly) begin
            @(negedge clk);
            check("rq_hold", core_rq, 1'b1);
         end
         core_busy = 1'b1;
         @(negedge clk);
         check("rq_drop", core_rq, 1'b0);
         for (int i = 1; i < blen; i++) begin
            @(negedge clk);
            check("busy_sel", sel, exp_sel);
            check("busy_nodone", done, 1'b0);
         end
         core_busy = 1'b0;
         @(negedge clk);
         check("done_pulse", done, 1'b1);
         check("done_sel", sel, '0);
         check("done_idx_hold", grant_idx, exp_idx);
         check("done_wdata", core_wdata, '0);
      end
      m_last = exp_idx;
   endtask

   initial begin
      logic [N-1:0] r, y;
      rstn = 1'b0;
      init_ack = 1'b0;
      req = '0;
      rdy = '0;
      core_busy = 1'b0;
      randomize_data();
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      req = 4'b1111;
      rdy = 4'b1111;
      repeat (20) begin
         @(negedge clk);
         check("noinit_rq", core_rq, 1'b0);
         check("noinit_sel", sel, '0);
      end

      init_ack = 1'b1;
      @(negedge clk);
      init_ack = 1'b0;

      xfer(4'b1111, 4'b1111, 2, 10, 0, 0, 0, 0);
      xfer(4'b1111, 4'b1111, 2, 10, 0, 0, 1, 1);
      xfer(4'b1111, 4'b1111, 2, 10, 0, 0, 1, 2);
      xfer(4'b1111, 4'b1111, 2, 10, 0, 0, 1, 3);
      xfer(4'b1111, 4'b1111, 2, 10, 0, 0, 1, 0);

      addr[2*CAW +: CAW] = 28'h0001000;
      xfer(4'b0100, 4'b1111, 3, 4, 0, 1, 1, 2);
      check("addr_slice2", core_addr, 28'h0001000);

      xfer(4'b0010, 4'b0010, 0, 0, 1, 0, 1, 1);
      xfer(4'b0110, 4'b1111, 1, 2, 0, 0, 1, 2);

      xfer(4'b1000, 4'b1000, 0, 1, 0, 0, 1, 3);
      xfer(4'b1001, 4'b1001, 0, 1, 0, 0, 1, 0);
      xfer(4'b1001, 4'b1001, 1, 2, 0, 0, 1, 3);
      xfer(4'b1001, 4'b1001, 0, 3, 0, 0, 1, 0);
      xfer(4'b1001, 4'b1001, 2, 1, 0, 0, 1, 3);

      // Reset while the core is bursting.
      req = 4'b0100;
      rdy = 4'b1111;
      @(negedge clk);
      check("rst_pre_rq", core_rq, 1'b1);
      core_busy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_pre_sel", sel, 4'b0100);
      #2 rstn = 1'b0;
      #1 check_all_zero("mid_reset");
      core_busy = 1'b0;
      req = 4'b1111;
      @(negedge clk);
      rstn = 1'b1;
      m_last = N - 1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_rq", core_rq, 1'b0);
         check("post_rst_done", done, 1'b0);
      end
      init_ack = 1'b1;
      @(negedge clk);
      init_ack = 1'b0;
      xfer(4'b1111, 4'b1111, 1, 2, 0, 0, 0, 0);

      for (int t = 0; t < 40; t++) begin
         r = 4'($urandom_range(1, 15));
         y = 4'($urandom) | (r & (~r + 4'd1));
         randomize_data();
         xfer(r, y, $urandom_range(0, 5), $urandom_range(1, 6), 0,
              1'($urandom_range(0, 1)), 1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
